// File: rtl/display_ctrl.sv
// display_ctrl: binary-to-seven-segment frame front-end with strobe/busy handshake; LEADING_ZERO_BLANK_EN blanks decimal leading zeros
module display_ctrl #(
  parameter int DATA_W = 16,
  parameter int N_DIGITS = 4,
  parameter int REFRESH_CYCLES = 4000
) (
  input  logic                  clk_i,
  input  logic                  sync_reset_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  mode_i,
  output logic [8*N_DIGITS-1:0] digits_o,
  output logic                  disp_strobe_o,
  input  logic                  busy_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  ovf_o
);
  localparam int BW = 4*N_DIGITS;
  localparam logic [7:0] SEG0 = 8'h3F;
  typedef enum logic [2:0] {IDLE, CONVERT, LOAD, TX_REQ, TX_WAIT, HOLD} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_snap, r_bin;
  logic r_mode, r_acc, r_ovf, r_done;
  logic [BW-1:0] r_bcd, r_nib, w_adj, w_bcd_nx, w_hex;
  logic [5:0] r_cnt;
  logic [31:0] r_ref, w_ext;
  logic [8*N_DIGITS-1:0] r_digits, w_seg;
  logic w_dec_ovf, w_hex_ovf, w_conv_done, w_changed;
  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
  endfunction
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIGITS; i++)
      w_adj[4*i+:4] = r_bcd[4*i+:4] > 4'd4 ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
  end
  assign w_bcd_nx = {w_adj[BW-2:0], r_bin[DATA_W-1]};
  assign w_dec_ovf = r_acc | w_adj[BW-1];
  assign w_ext = 32'(r_snap);
  assign w_hex = w_ext[BW-1:0];
  assign w_hex_ovf = |(w_ext >> BW);
  assign w_conv_done = !r_mode || r_cnt == 6'(DATA_W-1);
  assign w_changed = data_i != r_snap || mode_i != r_mode;
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic v_lead;
    v_lead = r_mode && !r_ovf;
`endif
    w_seg = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_seg[8*i+:8] = seg(r_nib[4*(N_DIGITS-1-i)+:4]);
`ifdef LEADING_ZERO_BLANK_EN
      v_lead = v_lead && r_nib[4*(N_DIGITS-1-i)+:4] == 4'd0 && i != N_DIGITS-1;
      if (v_lead) w_seg[8*i+:8] = 8'h00;
`endif
    end
  end
  always_ff @(posedge clk_i) r_state <= sync_reset_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = CONVERT;
      CONVERT: w_next = w_conv_done ? LOAD : CONVERT;
      LOAD:    w_next = TX_REQ;
      TX_REQ:  w_next = busy_i ? TX_WAIT : TX_REQ;
      TX_WAIT: w_next = busy_i ? TX_WAIT : HOLD;
      HOLD:    w_next = (w_changed || r_ref == 32'(REFRESH_CYCLES-1)) ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy_o = r_state != IDLE && r_state != HOLD;
    disp_strobe_o = r_state == TX_REQ;
  end
  always_ff @(posedge clk_i) begin
    if (sync_reset_i) begin
      r_digits <= {N_DIGITS{SEG0}};
      r_ovf <= 1'b0;
      r_done <= 1'b0;
      r_ref <= '0;
    end else begin
      r_done <= r_state == TX_WAIT && !busy_i;
      r_ref <= r_state == HOLD ? r_ref + 32'd1 : '0;
      if (r_state == IDLE) begin
        r_snap <= data_i;
        r_mode <= mode_i;
        r_bin <= data_i;
        r_bcd <= '0;
        r_acc <= 1'b0;
        r_cnt <= '0;
      end
      if (r_state == CONVERT) begin
        r_bin <= r_bin << 1;
        r_bcd <= w_bcd_nx;
        r_acc <= w_dec_ovf;
        r_cnt <= r_cnt + 6'd1;
        if (w_conv_done) begin
          r_ovf <= r_mode ? w_dec_ovf : w_hex_ovf;
          r_nib <= r_mode ? (w_dec_ovf ? {N_DIGITS{4'h9}} : w_bcd_nx) : (w_hex_ovf ? '1 : w_hex);
        end
      end
      if (r_state == LOAD) r_digits <= w_seg;
    end
  end
  assign digits_o = r_digits;
  assign frame_done_o = r_done;
  assign ovf_o = r_ovf;
endmodule
